fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage RV64 pipeline; produces the REG_IF_ID register consumed by the decode stage.
- Owns the PC and issues single-outstanding requests on the instruction bus.
- Buffers one returned instruction while the pipeline is stalled.
- Applies branch redirects from EX and drops stale in-flight responses; emits bubbles (valid=0) while waiting on memory.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
ireq_valid  output  1  fetch request valid; held until iresp_data_ok
ireq_addr  output  64  fetch address; stable while ireq_valid=1
iresp_data_ok  input  1  one-cycle pulse: response for current request
iresp_data  input  32  instruction word, valid with iresp_data_ok
redirect_valid  input  1  EX branch/jump taken
redirect_pc  input  64  redirect target
moduleOut  output  REG_IF_ID  valid, instr, instrAddr, pcPlus4 to decode
ok_to_proceed  output  1  stage-ready vote; constant 1 (bubbles instead of stalls)
ok_to_proceed_overall  input  1  global advance; pipeline registers update only when 1

Behaviour:
- One clock (clk), synchronous active-high reset (rst), sampled at posedge.
- Internal state:
  - pc (next instruction to deliver)
  - req_addr (address of outstanding request)
  - buf_instr / buf_addr (one-entry buffer)
  - FSM with states IDLE, WAIT, FULL, DISCARD
- Reset, applied at any time including mid-request:
  - state=IDLE, pc=RESET_PC
  - moduleOut.valid=0, other moduleOut fields don't-care
  - ireq_valid=0 while rst=1 and in IDLE
- Outputs:
  - ireq_valid = (state==WAIT || state==DISCARD).
  - ireq_addr = req_addr.
  - iresp_data_ok outside WAIT/DISCARD is ignored.
- IDLE:
  - Next cycle: req_addr<=pc, go WAIT (one-cycle gap after reset).
- WAIT, redirect applied (ok_to_proceed_overall=1 && redirect_valid):
  - pc<=redirect_pc.
  - If iresp_data_ok=1 this cycle: drop the response, req_addr<=redirect_pc, stay WAIT.
  - Else: go DISCARD.
  - moduleOut.valid<=0 (flush).
- WAIT, no redirect, iresp_data_ok=1:
  - If ok_to_proceed_overall=1: moduleOut<= {valid=1, instr=iresp_data, instrAddr=pc, pcPlus4=pc+4}; pc<=pc+4; req_addr<=pc+4; stay WAIT. This is the bypass path: response cycle N gives decode input valid at N+1.
  - If ok_to_proceed_overall=0: buf<=response, buf_addr<=pc, go FULL; moduleOut unchanged.
- WAIT, no response:
  - If ok_to_proceed_overall=1: moduleOut.valid<=0 (bubble).
- FULL (ireq_valid=0):
  - ok_to_proceed_overall=1 with redirect: pc<=redirect_pc, req_addr<=redirect_pc, drop buffer, moduleOut.valid<=0, go WAIT.
  - ok_to_proceed_overall=1 without redirect: moduleOut<=buffered instruction (instrAddr=buf_addr, pcPlus4=buf_addr+4); pc<=pc+4; req_addr<=pc+4; go WAIT.
  - ok_to_proceed_overall=0: hold everything.
- DISCARD:
  - Keep requesting req_addr (old) until iresp_data_ok; that response is dropped, then req_addr<=pc, go WAIT.
  - A further redirect (overall=1) updates pc only.
  - moduleOut.valid<=0 whenever overall=1.
- ok_to_proceed_overall=0 in any state:
  - moduleOut held bit-for-bit; redirect_valid ignored.
  - The memory response is still accepted per the rules above.
- Arithmetic: pc+4 is 64-bit modulo (wraps at 2^64). redirect_pc used verbatim; alignment faults belong to EX.
- Outstanding requests: at most one at any time; a new request is never issued before the prior data_ok.

Test Plan:
1. Reset with RESET_PC=0x8000_0000, memory with 1-cycle latency, overall=1 -> ireq_addr sequence 0x80000000, 0x80000004, 0x80000008. moduleOut.valid=1 with instr matching memory; pcPlus4=instrAddr+4. moduleOut.valid=0 during reset and in the first cycle after it.
2. Response at 0x80000004 arrives while overall=0 for 3 cycles -> state FULL, ireq_valid=0, moduleOut unchanged. On overall=1, moduleOut={1, word@0x80000004, 0x80000004, 0x80000008} and the next ireq_addr=0x80000008.
3. Redirect to 0x80001000 while a 4-cycle-latency request to 0x80000010 is pending -> ireq_addr stays 0x80000010 until data_ok; that word is never emitted (only valid=0 bubbles); next ireq_addr=0x80001000; first valid instrAddr=0x80001000.
4. Redirect in the same cycle as data_ok -> response dropped, moduleOut.valid=0, ireq_addr=redirect_pc on the next cycle.
5. Two redirects (0x100, then 0x200) during DISCARD -> first delivered instrAddr=0x200.
6. rst asserted with ireq_valid=1 and a late data_ok arriving in IDLE -> data_ok ignored, fetch restarts at RESET_PC, no valid output from the stale word.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV64 instruction fetch stage. Owns the PC, keeps one request in
//            flight on the instruction bus, buffers one word under stall and
//            flushes on EX redirects. moduleOut = {valid, instr, instrAddr, pcPlus4}.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         iresp_data_ok,
    input  logic [31:0]  iresp_data,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic [160:0] moduleOut,
    output logic         ok_to_proceed,
    input  logic         ok_to_proceed_overall
);

    localparam logic [63:0] c_PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_FULL    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_addr;
    logic [31:0] r_buf_instr;
    logic [63:0] r_buf_addr;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [63:0] r_out_addr;
    logic [63:0] r_out_pp4;

    logic        w_redirect;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_buf_plus4;

    // Redirects only count on cycles where the whole pipeline advances.
    assign w_redirect  = ok_to_proceed_overall && redirect_valid;
    assign w_pc_plus4  = r_pc + c_PC_STEP;
    assign w_buf_plus4 = r_buf_addr + c_PC_STEP;

    assign ireq_valid    = !rst && ((r_state == ST_WAIT) || (r_state == ST_DISCARD));
    assign ireq_addr     = r_req_addr;
    assign moduleOut     = {r_out_valid, r_out_instr, r_out_addr, r_out_pp4};
    assign ok_to_proceed = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_addr <= r_pc;
                    r_state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (w_redirect) begin
                        r_pc        <= redirect_pc;
                        r_out_valid <= 1'b0;
                        if (iresp_data_ok) begin
                            r_req_addr <= redirect_pc;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (iresp_data_ok) begin
                        if (ok_to_proceed_overall) begin
                            r_out_valid <= 1'b1;
                            r_out_instr <= iresp_data;
                            r_out_addr  <= r_pc;
                            r_out_pp4   <= w_pc_plus4;
                            r_pc        <= w_pc_plus4;
                            r_req_addr  <= w_pc_plus4;
                        end else begin
                            r_buf_instr <= iresp_data;
                            r_buf_addr  <= r_pc;
                            r_state     <= ST_FULL;
                        end
                    end else if (ok_to_proceed_overall) begin
                        r_out_valid <= 1'b0;
                    end
                end

                ST_FULL: begin
                    if (ok_to_proceed_overall) begin
                        if (redirect_valid) begin
                            r_pc        <= redirect_pc;
                            r_req_addr  <= redirect_pc;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_instr <= r_buf_instr;
                            r_out_addr  <= r_buf_addr;
                            r_out_pp4   <= w_buf_plus4;
                            r_pc        <= w_pc_plus4;
                            r_req_addr  <= w_pc_plus4;
                        end
                        r_state <= ST_WAIT;
                    end
                end

                ST_DISCARD: begin
                    if (w_redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (ok_to_proceed_overall) begin
                        r_out_valid <= 1'b0;
                    end
                    // A redirect landing with the stale response must win the next fetch.
                    if (iresp_data_ok) begin
                        r_req_addr <= w_redirect ? redirect_pc : r_pc;
                        r_state    <= ST_WAIT;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: bus model with latency and
//            response budget, expected-address scoreboard, redirect table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [63:0] c_RESET_PC = 64'h0000_0000_8000_0000;

    logic         clk;
    logic         rst;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         iresp_data_ok;
    logic [31:0]  iresp_data;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic [160:0] moduleOut;
    logic         ok_to_proceed;
    logic         ok_to_proceed_overall;

    fetch_stage #(.RESET_PC(c_RESET_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ireq_valid            (ireq_valid),
        .ireq_addr             (ireq_addr),
        .iresp_data_ok         (iresp_data_ok),
        .iresp_data            (iresp_data),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .moduleOut             (moduleOut),
        .ok_to_proceed         (ok_to_proceed),
        .ok_to_proceed_overall (ok_to_proceed_overall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          budget   = 0;
    int          mem_lat  = 1;
    bit          mem_inject = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] last_pp4 = 64'd0;

    typedef struct {
        logic [63:0] target;
        int          lat;
        int          n;
        logic [63:0] last_pp4;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [160:0] act, input logic [160:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Instruction memory: one request at a time, answers after mem_lat counted
    // cycles, and only while budget remains.
    initial begin
        bit          busy = 1'b0;
        int          cnt  = 0;
        logic [63:0] cap  = 64'd0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            iresp_data_ok = 1'b0;
            if (mem_inject) begin
                iresp_data_ok = 1'b1;
                iresp_data    = 32'hDEAD_BEEF;
            end else if (ireq_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    cap  = ireq_addr;
                end else begin
                    check("ireq_addr_stable", ireq_addr, cap);
                end
                if (budget > 0) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = mem_word(cap);
                        budget--;
                        busy = 1'b0;
                        req_log.push_back(cap);
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Output monitor: each advancing edge either flushes, bubbles or delivers
    // the next address the scoreboard expects.
    initial begin
        logic [160:0] prev_out = '0;
        logic         adv, rs, redir;
        logic [63:0]  e;
        forever begin
            @(posedge clk);
            adv   = ok_to_proceed_overall;
            rs    = rst;
            redir = redirect_valid;
            #1;
            if (rs) begin
                check("reset_valid", {63'd0, moduleOut[160]}, 64'd0);
            end else if (!adv) begin
                check_w("hold_moduleOut", moduleOut, prev_out);
            end else if (redir) begin
                check("flush_valid", {63'd0, moduleOut[160]}, 64'd0);
            end else if (moduleOut[160]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instrAddr", moduleOut[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("instrAddr", moduleOut[127:64], e);
                    check("instr", {32'd0, moduleOut[159:128]}, {32'd0, mem_word(e)});
                    check("pcPlus4", moduleOut[63:0], e + 64'd4);
                    last_pp4 = moduleOut[63:0];
                end
            end
            prev_out = moduleOut;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{target: 64'h0000_0000_8000_4000, lat: 1, n: 3, last_pp4: 64'h0000_0000_8000_400C};
        vecs[1] = '{target: 64'hFFFF_FFFF_FFFF_FFFC, lat: 2, n: 2, last_pp4: 64'h0000_0000_0000_0004};
        vecs[2] = '{target: 64'h1234_5678_9ABC_DEF0, lat: 3, n: 2, last_pp4: 64'h1234_5678_9ABC_DEF8};
        vecs[3] = '{target: 64'h7FFF_FFFF_FFFF_FFF8, lat: 1, n: 3, last_pp4: 64'h8000_0000_0000_0004};

        rst = 1'b1;
        ok_to_proceed_overall = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;

        // 1: reset, then three back-to-back fetches at 1-cycle latency
        repeat (3) @(negedge clk);
        #2;
        check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        check("ok_to_proceed", {63'd0, ok_to_proceed}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 1;
        budget = 3;
        exp_q.push_back(c_RESET_PC);
        exp_q.push_back(c_RESET_PC + 64'd4);
        exp_q.push_back(c_RESET_PC + 64'd8);
        #2;
        check("idle_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        check("idle_out_valid", {63'd0, moduleOut[160]}, 64'd0);
        @(negedge clk);
        #2;
        check("first_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        check("first_ireq_addr", ireq_addr, c_RESET_PC);
        wait_drain(100);
        check("t1_req_count", req_log.size(), 3);
        check("t1_req2", req_log[2], c_RESET_PC + 64'd8);
        req_log.delete();

        // 2: response arrives under stall; redirect during stall is ignored
        ok_to_proceed_overall = 1'b0;
        budget = 1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_0000_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("full_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        end
        redirect_valid = 1'b0;
        ok_to_proceed_overall = 1'b1;
        exp_q.push_back(c_RESET_PC + 64'd12);
        @(negedge clk);
        #2;
        check("after_full_ireq_addr", ireq_addr, c_RESET_PC + 64'd16);
        wait_drain(50);
        req_log.delete();

        // 3: redirect while a 4-cycle request to 0x80000010 is pending
        @(negedge clk);
        mem_lat = 4;
        budget = 3;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_1000;
        exp_q.push_back(64'h0000_0000_8000_1000);
        exp_q.push_back(64'h0000_0000_8000_1004);
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_drain(100);
        check("t3_stale_addr", req_log[0], c_RESET_PC + 64'd16);
        check("t3_next_addr", req_log[1], 64'h0000_0000_8000_1000);
        req_log.delete();

        // 4: redirect in the same cycle as data_ok
        mem_lat = 1;
        budget = 2;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_2000;
        exp_q.push_back(64'h0000_0000_8000_2000);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        check("t4_out_valid", {63'd0, moduleOut[160]}, 64'd0);
        check("t4_ireq_addr", ireq_addr, 64'h0000_0000_8000_2000);
        wait_drain(50);
        req_log.delete();

        // 5: two redirects during DISCARD; the later one wins
        mem_lat = 4;
        budget = 0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        redirect_pc = 64'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        budget = 2;
        exp_q.push_back(64'h200);
        wait_drain(100);
        check("t5_next_addr", req_log[1], 64'h200);
        req_log.delete();

        // Redirect table, including the 64-bit wrap of pc+4
        for (int v = 0; v < 4; v++) begin
            mem_lat = vecs[v].lat;
            budget = 1 + vecs[v].n;
            redirect_valid = 1'b1;
            redirect_pc = vecs[v].target;
            for (int j = 0; j < vecs[v].n; j++) begin
                exp_q.push_back(vecs[v].target + 64'(4 * j));
            end
            @(negedge clk);
            redirect_valid = 1'b0;
            wait_drain(100);
            check("vec_last_pcPlus4", last_pp4, vecs[v].last_pp4);
        end
        req_log.delete();

        // 6: reset mid-request, stale data_ok lands while in IDLE
        budget = 0;
        rst = 1'b1;
        #2;
        check("t6_rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_inject = 1'b1;
        #2;
        check("t6_idle_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        @(negedge clk);
        mem_inject = 1'b0;
        mem_lat = 1;
        budget = 1;
        exp_q.push_back(c_RESET_PC);
        #2;
        check("t6_restart_valid", {63'd0, ireq_valid}, 64'd1);
        check("t6_restart_addr", ireq_addr, c_RESET_PC);
        wait_drain(50);
        check("t6_req_count", req_log.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
